// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch_stage (master) and imem (slave).
interface fetch_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests, buffers in-order responses.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_squashed counters.
module fetch_stage #(
    parameter int unsigned          XLEN      = 32,
    parameter logic [XLEN-1:0]      RESET_PC  = XLEN'(32'h0000_0200),
    parameter int unsigned          BUF_DEPTH = 2,
    parameter logic [31:0]          NOP_INST  = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    fetch_stage_if.master   imem,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            if_kill,
    input  logic            dec_stall,
    output logic            dec_valid,
    output logic [31:0]     dec_inst,
    output logic [XLEN-1:0] dec_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_squashed
`endif
);
    localparam int unsigned   AW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned   CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic {S_FETCH = 1'b0, S_FLUSH = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   inflight_q, inflight_d, drop_q, drop_d, buf_cnt_q, buf_cnt_d;
    logic [AW-1:0]   pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
    logic [AW-1:0]   buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
    logic [XLEN-1:0] pcq_q     [BUF_DEPTH];
    logic [XLEN-1:0] pcq_d     [BUF_DEPTH];
    logic [XLEN-1:0] buf_pc_q  [BUF_DEPTH];
    logic [XLEN-1:0] buf_pc_d  [BUF_DEPTH];
    logic [31:0]     buf_inst_q[BUF_DEPTH];
    logic [31:0]     buf_inst_d[BUF_DEPTH];
    logic            dec_valid_q, dec_valid_d;
    logic [31:0]     dec_inst_q, dec_inst_d;
    logic [XLEN-1:0] dec_pc_q, dec_pc_d;

    logic            req_valid_c, req_fire_c, resp_drop_c, resp_take_c;
    logic            squash_c, pop_c, bypass_c, push_c;
    logic [XLEN-1:0] req_addr_c;

    // Handshake decode: credits cover in-flight requests plus buffered instructions
    always_comb begin
        req_addr_c  = {pc_q[XLEN-1:2], 2'b00};
        req_valid_c = !reset && (state_q == S_FETCH) && !redirect_valid
                      && ((inflight_q + buf_cnt_q) < DEPTH_C);
        req_fire_c  = req_valid_c && imem.imem_req_ready;
        resp_drop_c = imem.imem_resp_valid && (drop_q != '0);
        resp_take_c = imem.imem_resp_valid && (drop_q == '0);
        squash_c    = !dec_stall && (if_kill || redirect_valid);
        pop_c       = !dec_stall && !squash_c && (buf_cnt_q != '0);
        bypass_c    = !dec_stall && !squash_c && (buf_cnt_q == '0) && resp_take_c;
        push_c      = resp_take_c && !bypass_c && !redirect_valid;
    end

    assign imem.imem_req_valid = req_valid_c;
    assign imem.imem_req_addr  = req_addr_c;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pcq_d       = pcq_q;
        pcq_wr_d    = pcq_wr_q;
        pcq_rd_d    = pcq_rd_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
        buf_wr_d    = buf_wr_q;
        buf_rd_d    = buf_rd_q;
        dec_valid_d = dec_valid_q;
        dec_inst_d  = dec_inst_q;
        dec_pc_d    = dec_pc_q;
        inflight_d  = inflight_q + CW'(req_fire_c) - CW'(imem.imem_resp_valid);
        drop_d      = drop_q - CW'(resp_drop_c);
        buf_cnt_d   = buf_cnt_q + CW'(push_c) - CW'(pop_c);

        if (req_fire_c) begin
            pcq_d[pcq_wr_q] = req_addr_c;
            pcq_wr_d        = pcq_wr_q + AW'(1);
            pc_d            = pc_q + XLEN'(4);
        end
        if (resp_take_c) begin
            pcq_rd_d = pcq_rd_q + AW'(1);
        end
        if (push_c) begin
            buf_pc_d[buf_wr_q]   = pcq_q[pcq_rd_q];
            buf_inst_d[buf_wr_q] = imem.imem_resp_data;
            buf_wr_d             = buf_wr_q + AW'(1);
        end
        if (pop_c) begin
            buf_rd_d = buf_rd_q + AW'(1);
        end

        // Decode register only moves when decode is not stalled
        if (!dec_stall) begin
            if (squash_c) begin
                dec_valid_d = 1'b0;
                dec_inst_d  = NOP_INST;
            end else if (pop_c) begin
                dec_valid_d = 1'b1;
                dec_inst_d  = buf_inst_q[buf_rd_q];
                dec_pc_d    = buf_pc_q[buf_rd_q];
            end else if (bypass_c) begin
                dec_valid_d = 1'b1;
                dec_inst_d  = imem.imem_resp_data;
                dec_pc_d    = pcq_q[pcq_rd_q];
            end else begin
                dec_valid_d = 1'b0;
                dec_inst_d  = NOP_INST;
            end
        end

        // No request issues on a redirect, so every remaining in-flight response is stale
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            pcq_wr_d  = '0;
            pcq_rd_d  = '0;
            buf_wr_d  = '0;
            buf_rd_d  = '0;
            buf_cnt_d = '0;
            drop_d    = inflight_d;
            state_d   = (inflight_d != '0) ? S_FLUSH : S_FETCH;
        end else if ((state_q == S_FLUSH) && (drop_d == '0)) begin
            state_d = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            inflight_q  <= '0;
            drop_q      <= '0;
            buf_cnt_q   <= '0;
            pcq_wr_q    <= '0;
            pcq_rd_q    <= '0;
            buf_wr_q    <= '0;
            buf_rd_q    <= '0;
            dec_valid_q <= 1'b0;
            dec_inst_q  <= NOP_INST;
            dec_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            drop_q      <= drop_d;
            buf_cnt_q   <= buf_cnt_d;
            pcq_wr_q    <= pcq_wr_d;
            pcq_rd_q    <= pcq_rd_d;
            buf_wr_q    <= buf_wr_d;
            buf_rd_q    <= buf_rd_d;
            dec_valid_q <= dec_valid_d;
            dec_inst_q  <= dec_inst_d;
            dec_pc_q    <= dec_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        pcq_q      <= pcq_d;
        buf_pc_q   <= buf_pc_d;
        buf_inst_q <= buf_inst_d;
    end

    assign dec_valid = dec_valid_q;
    assign dec_inst  = dec_inst_q;
    assign dec_pc    = dec_pc_q;

    // The credit rule guarantees a free slot for every accepted response
    assert property (@(posedge clk) disable iff (reset) !(resp_take_c && (buf_cnt_q == DEPTH_C)));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d, perf_squashed_q, perf_squashed_d;

    always_comb begin
        perf_fetched_d  = perf_fetched_q + 32'(pop_c || bypass_c);
        perf_squashed_d = perf_squashed_q + 32'(resp_drop_c) + 32'(squash_c && dec_valid_q);
        if (redirect_valid) begin
            perf_squashed_d = perf_squashed_d + 32'(buf_cnt_q) + 32'(resp_take_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the decode/control path.
- Owns the PC, issues pipelined imem read requests and buffers in-order responses.
- Presents {valid, pc, inst} to decode each cycle and honours decode stall, if_kill and branch/jump redirects from the execute stage.

Parameters:
XLEN, 32, datapath/PC width.
RESET_PC, 32'h0000_0200, first fetch address after reset.
BUF_DEPTH, 2, response buffer entries = max in-flight requests + buffered instructions (power of 2, >=2).
NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on dec_inst when invalid.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  XLEN  fetch address (word aligned)
imem_req_ready  input  1  imem accepts request this cycle
imem_resp_valid  input  1  read data valid (in order, >=1 cycle after accept)
imem_resp_data  input  32  instruction word
redirect_valid  input  1  execute-stage PC redirect (branch taken / jal / jalr)
redirect_pc  input  XLEN  redirect target
if_kill  input  1  squash the instruction entering decode this cycle
dec_stall  input  1  decode holds (hazard or cache-miss stall)
dec_valid  output  1  decode register holds a live instruction
dec_inst  output  32  decode instruction word
dec_pc  output  XLEN  decode instruction PC

Behaviour:
- Reset (sync, active-high; wins over all other inputs, also mid-operation): pc=RESET_PC, state=FETCH, buffer empty, inflight=0, drop=0, imem_req_valid=0 during reset cycle, dec_valid=0, dec_inst=NOP_INST, dec_pc=0.
- Credits: imem_req_valid = (state==FETCH) && (inflight + occupancy < BUF_DEPTH) && !redirect_valid. Request accepted on valid&&ready: pc += 4 (wraps modulo 2^XLEN), inflight++. imem_req_addr = pc, pc[1:0] forced 0.
- Response: imem_resp_valid with drop>0 -> discard, drop--, inflight--. Otherwise push {pc_of_request, data} into buffer, inflight--. Request PCs are tracked in a BUF_DEPTH-entry PC queue paired with the data. Response arriving while buffer full is impossible by credit rule; assertion flags it.
- Decode register advance when !dec_stall: if if_kill or redirect_valid -> dec_valid=0, dec_inst=NOP_INST; else if buffer non-empty -> pop head into decode (dec_valid=1); else bubble. Same-cycle push and pop on an empty buffer bypasses: response data reaches decode the following cycle (fetch latency = imem latency + 1).
- dec_stall=1: decode register and buffer head hold; responses still land in buffer; if_kill ignored while stalled (execute redirect still applies).
- Redirect (redirect_valid=1): buffer flushed, pc=redirect_pc, drop=inflight minus any response consumed this cycle, state=FLUSH if drop nonzero else FETCH. No request issued in redirect cycle; first request at redirect_pc next cycle (FETCH) or after drain.
- FSM: FETCH -> FLUSH on redirect with outstanding requests; FLUSH -> FETCH when drop reaches 0; a redirect in FLUSH updates pc and recomputes drop; FLUSH issues no requests.
- Simultaneous redirect and if_kill: redirect dominates; both produce a bubble.

Optional Feature:
FETCH_PERF_CNT_EN: adds outputs perf_fetched (32 bits: instructions popped into decode with dec_valid=1) and perf_squashed (32 bits: buffered entries flushed + dropped responses + killed decode entries); both cleared on reset, wrap at 2^32. Without the macro: ports and counters absent, behaviour otherwise identical.

Test Plan:
- Reset, imem ready always, 1-cycle latency, data = addr -> dec_pc sequence 0x200,0x204,0x208 on consecutive cycles, first dec_valid=1 three cycles after reset deasserts.
- imem_req_ready low 5 cycles -> imem_req_addr held at 0x204, no pc increment, dec_valid=0 bubbles, no duplicate pc in decode.
- dec_stall 4 cycles with responses pending -> dec_inst/dec_pc frozen, imem_req_valid drops once inflight+occupancy=2, resumes in order with no loss.
- Redirect to 0x1000 with 2 in flight -> both late responses dropped, state FLUSH 2 cycles, next dec_pc=0x1000, never 0x20C.
- if_kill pulse while buffer holds 0x208 -> dec_valid=0, dec_inst=32'h13 for one cycle; 0x208 not lost, appears next cycle (kill affects only the entry entering decode).
- reset asserted mid-FLUSH with responses arriving -> outputs return to reset values next cycle, late responses ignored, fetch restarts at 0x200.
